// File: rtl/small_mario_sprite_fetch.sv
// ----------------------------------------------------------------------------
// small_mario_sprite_fetch
//
// Pixel-rate fetch stage in front of the small-Mario palette lookup. For every
// VGA pixel it decides whether the pixel falls inside Mario's bounding box. It
// then forms the sprite ROM address from the animation frame, the row and the
// (optionally mirrored) column. Finally it returns the ROM's palette index and
// a sprite_on flag, aligned three clock edges after draw_x/draw_y.
//
// Mario's position and facing are captured into shadow registers on
// frame_start, so a frame is never drawn with a half-updated pose. The
// walk/jump animation FSM also advances only on frame_start.
//
// Ports:
//   clk           pixel clock
//   reset_n       asynchronous active-low reset
//   draw_x/draw_y current pixel column/row from the VGA controller
//   pix_valid     high during active video
//   frame_start   one-cycle pulse at vsync (start of blanking)
//   mario_x/y     sprite top-left corner from game logic
//   facing_left   mirror sprite horizontally
//   walking       Mario moving on the ground
//   jumping       Mario airborne (wins over walking)
//   rom_addr      registered sprite ROM read address
//   rom_data      ROM palette index, valid one cycle after rom_addr
//   palette_index index to the palette block; 0 outside the box
//   sprite_on     inside the box and index is not transparent
// ----------------------------------------------------------------------------
module small_mario_sprite_fetch #(
    parameter int unsigned SPRITE_W   = 16,
    parameter int unsigned SPRITE_H   = 16,
    parameter int unsigned ANIM_DIV   = 6,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned TRANSP_IDX = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [9:0]        mario_x,
    input  logic [9:0]        mario_y,
    input  logic              facing_left,
    input  logic              walking,
    input  logic              jumping,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        palette_index,
    output logic              sprite_on
);

    localparam int unsigned COL_W = $clog2(SPRITE_W);
    localparam int unsigned ROW_W = $clog2(SPRITE_H);
    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(SPRITE_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic [3:0]       TRANSP   = 4'(TRANSP_IDX);
    localparam logic [10:0]      W_EXT    = 11'(SPRITE_W);
    localparam logic [10:0]      H_EXT    = 11'(SPRITE_H);

    // ------------------------------------------------------------------------
    // Shadow copy of Mario's pose, refreshed once per video frame
    // ------------------------------------------------------------------------
    logic [9:0] sx_q;
    logic [9:0] sy_q;
    logic       sflip_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            sflip_q <= 1'b0;
        end else if (frame_start) begin
            sx_q    <= mario_x;
            sy_q    <= mario_y;
            sflip_q <= facing_left;
        end
    end

    // ------------------------------------------------------------------------
    // Animation FSM: STAND -> frame 0, WALK -> walk_frame (1..3), JUMP -> 4
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StStand,
        StWalk,
        StJump
    } anim_e;

    anim_e            anim_q, anim_d;
    logic [1:0]       walk_frame_q, walk_frame_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_q       <= StStand;
            walk_frame_q <= 2'd1;
            div_cnt_q    <= '0;
        end else begin
            anim_q       <= anim_d;
            walk_frame_q <= walk_frame_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    always_comb begin
        anim_d       = anim_q;
        walk_frame_d = walk_frame_q;
        div_cnt_d    = div_cnt_q;
        if (frame_start) begin
            if (jumping) begin
                anim_d = StJump;
            end else if (walking) begin
                anim_d = StWalk;
            end else begin
                anim_d = StStand;
            end

            if (anim_d == StWalk) begin
                if (anim_q != StWalk) begin
                    // Every new walk starts on the first stride frame.
                    walk_frame_d = 2'd1;
                    div_cnt_d    = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d    = '0;
                    walk_frame_d = (walk_frame_q == 2'd3) ? 2'd1 : walk_frame_q + 2'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        frame = 3'd0;
        unique case (anim_q)
            StStand: frame = 3'd0;
            StWalk:  frame = {1'b0, walk_frame_q};
            StJump:  frame = 3'd4;
            default: frame = 3'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage 1: box test and ROM address
    // ------------------------------------------------------------------------
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              in_box;
    logic [COL_W-1:0]  col_raw;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_calc;

    always_comb begin
        // 11-bit bounds so a sprite near column 1023 clips instead of wrapping.
        x_end  = {1'b0, sx_q} + W_EXT;
        y_end  = {1'b0, sy_q} + H_EXT;
        in_box = pix_valid
               && (draw_x >= sx_q) && ({1'b0, draw_x} < x_end)
               && (draw_y >= sy_q) && ({1'b0, draw_y} < y_end);

        // Only the low bits of the offset matter once the pixel is in the box.
        col_raw = draw_x[COL_W-1:0] - sx_q[COL_W-1:0];
        row     = draw_y[ROW_W-1:0] - sy_q[ROW_W-1:0];
        col     = sflip_q ? (COL_MAX - col_raw) : col_raw;

        // Power-of-two sprite dimensions make the address a plain bit packing.
        addr_calc = (ADDR_W'(frame) << (COL_W + ROW_W))
                  | (ADDR_W'(row) << COL_W)
                  | ADDR_W'(col);
    end

    logic v1_q;
    logic v2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            v1_q     <= 1'b0;
        end else begin
            rom_addr <= in_box ? addr_calc : '0;
            v1_q     <= in_box;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: ROM access in flight; carry the in-box flag alongside it
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: qualified palette index and visibility flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            palette_index <= 4'd0;
            sprite_on     <= 1'b0;
        end else begin
            palette_index <= v2_q ? rom_data : 4'd0;
            sprite_on     <= v2_q && (rom_data != TRANSP);
        end
    end

endmodule

// File: tb/tb_small_mario_sprite_fetch.sv
module tb_small_mario_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  mario_x = '0;
    logic [9:0]  mario_y = '0;
    logic        facing_left = 1'b0;
    logic        walking = 1'b0;
    logic        jumping = 1'b0;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  palette_index;
    logic        sprite_on;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    small_mario_sprite_fetch #(
        .SPRITE_W  (16),
        .SPRITE_H  (16),
        .ANIM_DIV  (2),
        .ADDR_W    (11),
        .TRANSP_IDX(0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .facing_left  (facing_left),
        .walking      (walking),
        .jumping      (jumping),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .palette_index(palette_index),
        .sprite_on    (sprite_on)
    );

    // Synchronous ROM model: palette index is the low nibble of the address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rom_data <= 4'd0;
        else          rom_data <= rom_addr[3:0];
    end

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [10:0] addr;
        logic [3:0]  pal;
        logic        on;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse_frame();
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic probe(input string nm, input int x, input int y, input int exp);
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        pix_valid = 1'b1;
        @(posedge clk); #1;
        check(nm, int'(rom_addr), exp);
        pix_valid = 1'b0;
    endtask

    // Streams vectors back to back; the output for vector i appears on the
    // third edge counted from the one that samples it.
    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi + 2; i++) begin
            if (i <= hi) begin
                draw_x    = vecs[i].x;
                draw_y    = vecs[i].y;
                pix_valid = vecs[i].v;
            end else begin
                draw_x    = '0;
                draw_y    = '0;
                pix_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i <= hi) check($sformatf("addr[%0d]", i), int'(rom_addr), int'(vecs[i].addr));
            if (i >= lo + 2) begin
                check($sformatf("pal[%0d]", i - 2), int'(palette_index), int'(vecs[i-2].pal));
                check($sformatf("on[%0d]", i - 2), int'(sprite_on), int'(vecs[i-2].on));
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Stand pose at sx=100, sy=50
        vecs[0]  = '{10'd99,  10'd50, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[1]  = '{10'd100, 10'd50, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[2]  = '{10'd101, 10'd50, 1'b1, 11'd1,   4'd1,  1'b1};
        vecs[3]  = '{10'd115, 10'd50, 1'b1, 11'd15,  4'd15, 1'b1};
        vecs[4]  = '{10'd116, 10'd50, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[5]  = '{10'd115, 10'd65, 1'b1, 11'd255, 4'd15, 1'b1};
        vecs[6]  = '{10'd115, 10'd66, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[7]  = '{10'd100, 10'd49, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[8]  = '{10'd105, 10'd60, 1'b0, 11'd0,   4'd0,  1'b0};
        vecs[9]  = '{10'd105, 10'd60, 1'b1, 11'd165, 4'd5,  1'b1};
        vecs[10] = '{10'd102, 10'd51, 1'b1, 11'd18,  4'd2,  1'b1};
        // Mirrored
        vecs[11] = '{10'd100, 10'd50, 1'b1, 11'd15,  4'd15, 1'b1};
        vecs[12] = '{10'd115, 10'd50, 1'b1, 11'd0,   4'd0,  1'b0};
        vecs[13] = '{10'd101, 10'd51, 1'b1, 11'd30,  4'd14, 1'b1};
        vecs[14] = '{10'd116, 10'd50, 1'b1, 11'd0,   4'd0,  1'b0};

        // Reset state
        #2;
        check("reset_addr", int'(rom_addr), 0);
        check("reset_pal", int'(palette_index), 0);
        check("reset_on", int'(sprite_on), 0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Bounds and latency
        mario_x = 10'd100;
        mario_y = 10'd50;
        pulse_frame();
        run_table(0, 10);

        // Horizontal flip
        facing_left = 1'b1;
        pulse_frame();
        run_table(11, 14);

        // Walk animation with ANIM_DIV=2
        facing_left = 1'b0;
        walking     = 1'b1;
        pulse_frame(); probe("walk1", 100, 50, 256);
        pulse_frame(); probe("walk2", 100, 50, 256);
        pulse_frame(); probe("walk3", 100, 50, 512);
        pulse_frame(); probe("walk4", 100, 50, 512);
        pulse_frame(); probe("walk5", 100, 50, 768);
        pulse_frame(); probe("walk6", 100, 50, 768);
        pulse_frame(); probe("walk7", 100, 50, 256);
        jumping = 1'b1;
        pulse_frame(); probe("jump", 100, 50, 1024);
        jumping = 1'b0;
        pulse_frame(); probe("rewalk", 100, 50, 256);
        walking = 1'b0;
        pulse_frame(); probe("stand", 101, 50, 1);

        // Tearing guard
        mario_x = 10'd200;
        probe("tear_old_in", 101, 50, 1);
        probe("tear_new_out", 201, 50, 0);
        draw_x      = 10'd101;
        draw_y      = 10'd50;
        pix_valid   = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        check("tear_coincident", int'(rom_addr), 1);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        probe("tear_new_in", 201, 50, 1);
        probe("tear_old_out", 101, 50, 0);

        // Right-edge overflow
        mario_x = 10'd1020;
        pulse_frame();
        probe("edge_1023", 1023, 50, 3);
        probe("edge_1021", 1021, 50, 1);
        probe("edge_wrap0", 0, 50, 0);

        // Reset mid-stream
        mario_x = 10'd100;
        pulse_frame();
        draw_x    = 10'd101;
        draw_y    = 10'd50;
        pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_pal", int'(palette_index), 1);
        check("pre_reset_on", int'(sprite_on), 1);
        reset_n = 1'b0;
        #1;
        check("async_pal", int'(palette_index), 0);
        check("async_on", int'(sprite_on), 0);
        check("async_addr", int'(rom_addr), 0);
        // Shadow regs are back at (0,0), so pixel (1,0) is in box.
        draw_x = 10'd1;
        draw_y = 10'd0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel1_addr", int'(rom_addr), 1);
        check("rel1_pal", int'(palette_index), 0);
        check("rel1_on", int'(sprite_on), 0);
        @(posedge clk); #1;
        check("rel2_pal", int'(palette_index), 0);
        check("rel2_on", int'(sprite_on), 0);
        @(posedge clk); #1;
        check("rel3_pal", int'(palette_index), 1);
        check("rel3_on", int'(sprite_on), 1);
        pix_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
